// File: rtl/ecc_pkg.sv
// Shared constants for the (39,32) SEC-DED path: widths, H-matrix check rows and
// the storage controller state encoding.
package ecc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 7;
  localparam int unsigned CODE_W = 40;

  // Each row selects the data bits XORed into one check bit.
  localparam logic [DATA_W-1:0] CHK_ROW0 = 32'h2C02_21FF;
  localparam logic [DATA_W-1:0] CHK_ROW1 = 32'h13E5_101F;
  localparam logic [DATA_W-1:0] CHK_ROW2 = 32'hC06C_89E1;
  localparam logic [DATA_W-1:0] CHK_ROW3 = 32'h7D9C_4422;
  localparam logic [DATA_W-1:0] CHK_ROW4 = 32'hA2BB_C244;
  localparam logic [DATA_W-1:0] CHK_ROW5 = 32'h8B50_3E88;
  localparam logic [DATA_W-1:0] CHK_ROW6 = 32'h5403_FF10;

  localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_ROWS = {
    CHK_ROW6, CHK_ROW5, CHK_ROW4, CHK_ROW3, CHK_ROW2, CHK_ROW1, CHK_ROW0
  };

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StEnc,
    StWr,
    StRd
  } ctrl_state_e;

endpackage

// File: rtl/ecc_encoder.sv
// Combinational check-bit generator for the (39,32) code; shared with the
// decoder's syndrome logic.
module ecc_encoder
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CHK_W-1:0]  chk_o
);

  always_comb begin
    chk_o = '0;
    for (int i = 0; i < CHK_W; i++) begin
      chk_o[i] = ^(data_i & CHK_ROWS[i]);
    end
  end

endmodule

// File: rtl/enc_sram_ctrl.sv
// Encode-and-store controller: clears the array after reset, then serves one
// read or write at a time, storing (optionally fault-injected) 40-bit codewords.
module enc_sram_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AW-1:0]     req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              inj_en_i,
  input  logic [CODE_W-1:0] inj_mask_i,
  output logic              rd_valid_o,
  output logic [CODE_W-1:0] rd_code_o,
  output logic [AW-1:0]     rd_addr_o,
  output logic              init_done_o
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  ctrl_state_e       state_q;
  logic [AW-1:0]     init_cnt_q;
  logic              req_ready_q;
  logic              rd_valid_q;
  logic [CODE_W-1:0] rd_code_q;
  logic [AW-1:0]     rd_addr_q;
  logic              init_done_q;

  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              inj_en_q;
  logic [CODE_W-1:0] inj_mask_q;
  logic [CODE_W-1:0] code_q;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [CODE_W-1:0] mem_wdata;

  logic [CHK_W-1:0]  chk;
  logic [CODE_W-1:0] code_masked;

  ecc_encoder u_encoder (
    .data_i (wdata_q),
    .chk_o  (chk)
  );

  assign code_masked = {1'b0, chk, wdata_q} ^ (inj_en_q ? inj_mask_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_code_q   <= '0;
      rd_addr_q   <= '0;
      init_done_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      inj_en_q    <= 1'b0;
      inj_mask_q  <= '0;
      code_q      <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LastAddr) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        StIdle: begin
          if (req_valid_i && req_ready_q) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            inj_en_q    <= inj_en_i;
            inj_mask_q  <= inj_mask_i;
            req_ready_q <= 1'b0;
            state_q     <= req_we_i ? StEnc : StRd;
          end
        end
        StEnc: begin
          code_q  <= code_masked;
          state_q <= StWr;
        end
        StWr: begin
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        StRd: begin
          rd_code_q   <= mem_q[addr_q];
          rd_addr_q   <= addr_q;
          rd_valid_q  <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  // Single write port shared by the clear sweep and the WR state.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_cnt_q;
    mem_wdata = '0;
    if (state_q == StInit) begin
      mem_we = 1'b1;
    end else if (state_q == StWr && we_q) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q;
      mem_wdata = code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_code_o   = rd_code_q;
  assign rd_addr_o   = rd_addr_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_enc_sram_ctrl.sv
// Directed bench for enc_sram_ctrl: init sweep, table of encoded writes/reads,
// back-to-back service intervals and reset during a write.
module tb_enc_sram_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          inj_en = 1'b0;
  logic [39:0]   inj_mask = '0;
  logic          rd_valid;
  logic [39:0]   rd_code;
  logic [AW-1:0] rd_addr;
  logic          init_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          inj;
    logic [39:0]   mask;
    logic [39:0]   exp;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  enc_sram_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .inj_en_i    (inj_en),
    .inj_mask_i  (inj_mask),
    .rd_valid_o  (rd_valid),
    .rd_code_o   (rd_code),
    .rd_addr_o   (rd_addr),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 40'(req_ready), 40'd1);
  endtask

  // Releases reset at a falling edge and counts cycles until req_ready rises.
  task automatic release_and_init();
    int n = 0;
    rst = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready !== 1'b1 && n < 40);
    check("init_cycles", 40'(n), 40'(DEPTH));
    check("init_done", 40'(init_done), 40'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 40'(req_ready), 40'd0);
    check({tag, "_rd_valid"}, 40'(rd_valid), 40'd0);
    check({tag, "_rd_code"}, rd_code, 40'd0);
    check({tag, "_rd_addr"}, 40'(rd_addr), 40'd0);
    check({tag, "_init_done"}, 40'(init_done), 40'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic inj,
                          input logic [39:0] m);
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    inj_en    = inj;
    inj_mask  = m;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    inj_en    = 1'b0;
    check("wr_ready_n0", 40'(req_ready), 40'd0);
    @(negedge clk);
    check("wr_ready_n1", 40'(req_ready), 40'd0);
    @(negedge clk);
    check("wr_ready_n2", 40'(req_ready), 40'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [39:0] exp, input string tag);
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_rd_valid_early"}, 40'(rd_valid), 40'd0);
    @(negedge clk);
    check({tag, "_rd_valid"}, 40'(rd_valid), 40'd1);
    check({tag, "_rd_code"}, rd_code, exp);
    check({tag, "_rd_addr"}, 40'(rd_addr), 40'(a));
    check({tag, "_ready_with_data"}, 40'(req_ready), 40'd1);
    @(negedge clk);
    check({tag, "_rd_valid_pulse"}, 40'(rd_valid), 40'd0);
  endtask

  // req_valid held high; write/read alternate on address 6.
  task automatic back_to_back();
    logic [31:0] wd [3];
    logic [39:0] wc [3];
    logic [39:0] exp_rd = '0;
    int c = 0;
    int last_c = 0;
    int idx = 0;
    int reads = 0;
    bit prev_wr = 1'b0;
    bit done = 1'b0;
    wd[0] = 32'h0000_0001; wc[0] = 40'h07_0000_0001;
    wd[1] = 32'h0000_0100; wc[1] = 40'h45_0000_0100;
    wd[2] = 32'h8000_0000; wc[2] = 40'h34_8000_0000;
    wait_ready();
    while (!done && c < 60) begin
      if (rd_valid === 1'b1) begin
        check($sformatf("b2b_rd_code%0d", reads), rd_code, exp_rd);
        check($sformatf("b2b_rd_addr%0d", reads), 40'(rd_addr), 40'd6);
        reads++;
      end
      if (req_ready === 1'b1) begin
        if (idx > 0) begin
          check($sformatf("b2b_interval%0d", idx), 40'(c - last_c), prev_wr ? 40'd3 : 40'd2);
        end
        last_c = c;
        if (idx == 6) begin
          req_valid = 1'b0;
          done = 1'b1;
        end else begin
          req_valid = 1'b1;
          req_addr  = 4'd6;
          req_we    = (idx % 2 == 0);
          if (idx % 2 == 0) begin
            req_wdata = wd[idx/2];
            prev_wr   = 1'b1;
          end else begin
            exp_rd  = wc[idx/2];
            prev_wr = 1'b0;
          end
          idx++;
        end
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("b2b_done", 40'(done), 40'd1);
    check("b2b_reads", 40'(reads), 40'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'd3,  32'h0000_0001, 1'b0, 40'h00_0000_0000, 40'h07_0000_0001};
    vecs[1] = '{4'd0,  32'hFFFF_FFFF, 1'b0, 40'h00_0000_0000, 40'h24_FFFF_FFFF};
    vecs[2] = '{4'd15, 32'h8000_0000, 1'b0, 40'h00_0000_0000, 40'h34_8000_0000};
    vecs[3] = '{4'd5,  32'h0000_0001, 1'b1, 40'h00_0000_0020, 40'h07_0000_0021};
    vecs[4] = '{4'd8,  32'h0000_0100, 1'b0, 40'h00_0000_0000, 40'h45_0000_0100};
    vecs[5] = '{4'd9,  32'h0001_0000, 1'b0, 40'h00_0000_0000, 40'h52_0001_0000};
    vecs[6] = '{4'd10, 32'h0000_0200, 1'b0, 40'h00_0000_0000, 40'h70_0000_0200};
    vecs[7] = '{4'd11, 32'h0000_0001, 1'b1, 40'h80_0000_0000, 40'h87_0000_0001};
    vecs[8] = '{4'd12, 32'hFFFF_FFFF, 1'b0, 40'hFF_FFFF_FFFF, 40'h24_FFFF_FFFF};
    vecs[9] = '{4'd13, 32'h0000_0101, 1'b0, 40'h00_0000_0000, 40'h42_0000_0101};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    release_and_init();

    do_read(4'd7, 40'h0, "init_addr7");
    do_read(4'd3, 40'h0, "init_addr3");

    for (int i = 0; i < NVEC; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].inj, vecs[i].mask);
    end
    for (int i = 0; i < NVEC; i++) begin
      do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    back_to_back();

    // Reset while the write to address 2 sits in WR.
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd2;
    req_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midwr");
    repeat (2) @(negedge clk);
    release_and_init();
    do_read(4'd2, 40'h0, "post_rst_addr2");
    do_read(4'd3, 40'h0, "post_rst_addr3");
    do_read(4'd6, 40'h0, "post_rst_addr6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
